mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// mc_controller -- multicycle control unit for an ARM-style datapath.
//
// A Moore FSM steps each instruction through FETCH/DECODE and then a
// class-specific path (memory, data-processing, branch). Datapath selects
// come from the current state. Write enables are additionally gated by the
// instruction's condition, which is checked against a local NZCV register.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-low
//   cond       : instr[31:28] condition field
//   op         : instr[27:26] class (00 DP, 01 MEM, 10 BR, 11 none)
//   funct      : instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
//   rd         : instr[15:12] destination register
//   aluFlags   : NZCV from the ALU (combinational)
//   pcWrite, memWrite, regWrite, irWrite : datapath write enables
//   adrSrc     : memory address select (0 = PC, 1 = ALU result)
//   resultSrc, aluSrcA, aluSrcB, immSrc, regSrc : datapath mux selects
//   aluControl : ALU operation (00 ADD, 01 SUB, 10 AND, 11 ORR)
//   state      : current FSM state, for debug
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] aluFlags,
  output logic       pcWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic       irWrite,
  output logic       adrSrc,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic [1:0] regSrc,
  output logic [1:0] aluControl,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] r_flags;
  logic       w_cond_ex;
  logic [3:0] w_cmd;
  logic       w_is_cmp;
  logic [1:0] w_alu_dec;
  logic       w_flag_load;
  logic       w_n, w_z, w_c, w_v;
  // raw enables before the reset override
  logic       w_pcw, w_mw, w_rw, w_irw;

  assign w_cmd    = funct[4:1];
  assign w_is_cmp = (w_cmd == CMD_CMP);
  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Condition check against the stored flags (not the live ALU flags).
  always_comb begin
    w_cond_ex = 1'b0;
    case (cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;  // 1111 is never executed
    endcase
  end

  always_comb begin
    w_alu_dec = 2'b00;
    case (w_cmd)
      CMD_ADD: w_alu_dec = 2'b00;
      CMD_SUB: w_alu_dec = 2'b01;
      CMD_CMP: w_alu_dec = 2'b01;
      CMD_AND: w_alu_dec = 2'b10;
      CMD_ORR: w_alu_dec = 2'b11;
      default: w_alu_dec = 2'b00;
    endcase
  end

  // Flags are captured on the edge that leaves EXECR/EXECI, using the
  // condition as evaluated with the old flags.
  assign w_flag_load = ((r_state == S_EXECR) || (r_state == S_EXECI)) &&
                       (funct[0] || w_is_cmp) && w_cond_ex;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  w_next = S_MEMADR;
          OP_BR:   w_next = S_BRANCH;
          OP_DP:   w_next = funct[5] ? S_EXECI : S_EXECR;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      default:  w_next = S_FETCH;  // writeback/branch and unused codes
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_flags <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (w_flag_load) r_flags <= aluFlags;
    end
  end

  always_comb begin
    w_pcw      = 1'b0;
    w_mw       = 1'b0;
    w_rw       = 1'b0;
    w_irw      = 1'b0;
    adrSrc     = 1'b0;
    resultSrc  = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    aluControl = 2'b00;
    case (r_state)
      S_FETCH: begin
        // PC increment is unconditional; the condition only gates the
        // instruction's own effects.
        w_irw     = 1'b1;
        w_pcw     = 1'b1;
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
      end
      S_DECODE: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
      end
      S_MEMADR: aluSrcB = 2'b01;
      S_MEMRD:  adrSrc  = 1'b1;
      S_MEMWR: begin
        adrSrc = 1'b1;
        w_mw   = w_cond_ex;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        w_rw      = w_cond_ex;
        w_pcw     = w_cond_ex && (rd == 4'd15);
      end
      S_EXECR: aluControl = w_alu_dec;
      S_EXECI: begin
        aluSrcB    = 2'b01;
        aluControl = w_alu_dec;
      end
      S_ALUWB: begin
        w_rw  = w_cond_ex & ~w_is_cmp;
        w_pcw = w_cond_ex && (rd == 4'd15);
      end
      S_BRANCH: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        resultSrc = 2'b10;
        w_pcw     = w_cond_ex;
      end
      default: ;
    endcase
  end

  // Reset overrides the FETCH decode so nothing is written while held.
  assign pcWrite  = w_pcw & reset;
  assign memWrite = w_mw  & reset;
  assign regWrite = w_rw  & reset;
  assign irWrite  = w_irw & reset;

  assign immSrc = (op == 2'b11) ? 2'b00 : op;
  assign regSrc = {op == OP_MEM, op == OP_BR};
  assign state  = r_state;

endmodule
